router_input_port: RTL and testbench

Router input stage that terminates one link from an upstream processor element. It buffers up to DEPTH single-flit packets in a FIFO and returns one credit per dequeued flit on `credit_out`, which drives the upstream PE's `ci`. It also presents the head flit together with a one-hot XY-routed output-port request to the router's switch allocator. DEPTH matches the upstream credit limit of 4.

---
 rtl/router_input_port.sv | 107 ++++++++++
 tb/tb_router_input_port.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/router_input_port.sv
// Router input stage: DEPTH-entry flit FIFO with registered credit return and
// XY-routed one-hot output-port request for the head flit.
module router_input_port #(
    parameter int unsigned DATA_W = 20,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned MY_X   = 0,
    parameter int unsigned MY_Y   = 0
) (
    input  logic              clk,
    input  logic              RST,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              credit_out,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic [4:0]        out_port,
    input  logic              out_ready,
    output logic              err_overflow
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [2:0] MY_X3 = 3'(MY_X);
    localparam logic [2:0] MY_Y3 = 3'(MY_Y);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_credit;
    logic              r_overflow;

    logic              w_full;
    logic              w_push;
    logic              w_pop;
    logic              w_drop;
    logic [2:0]        w_dest_x;
    logic [2:0]        w_dest_y;

    // Fullness is judged on the pre-edge count, so a same-cycle pop never makes room.
    assign w_full = (r_count == FULL_CNT);
    assign w_push = in_valid && !w_full;
    assign w_drop = in_valid && w_full;
    assign w_pop  = out_valid && out_ready;

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_credit   <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
            r_credit <= w_pop;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Storage carries no reset; contents are only visible once count is nonzero.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    assign out_data     = r_mem[r_rd_ptr];
    assign out_valid    = (r_count != '0);
    assign credit_out   = r_credit;
    assign err_overflow = r_overflow;

    assign w_dest_x = out_data[DATA_W-1 -: 3];
    assign w_dest_y = out_data[DATA_W-4 -: 3];

    // X first, then Y; bit0 Local, bit1 East, bit2 West, bit3 North, bit4 South.
    always_comb begin
        out_port = 5'b00000;
        if (out_valid) begin
            if (w_dest_x > MY_X3) begin
                out_port = 5'b00010;
            end else if (w_dest_x < MY_X3) begin
                out_port = 5'b00100;
            end else if (w_dest_y > MY_Y3) begin
                out_port = 5'b01000;
            end else if (w_dest_y < MY_Y3) begin
                out_port = 5'b10000;
            end else begin
                out_port = 5'b00001;
            end
        end
    end

endmodule

// File: tb/tb_router_input_port.sv
// Directed bench for router_input_port: vector table plus hand-written
// sequences for streaming, pointer wrap and mid-operation reset.
module tb_router_input_port;

    logic        clk;
    logic        RST;
    logic [19:0] in_data;
    logic        in_valid;
    logic        credit_out;
    logic [19:0] out_data;
    logic        out_valid;
    logic [4:0]  out_port;
    logic        out_ready;
    logic        err_overflow;

    int checks;
    int errors;

    router_input_port #(
        .DATA_W(20),
        .DEPTH (4),
        .MY_X  (2),
        .MY_Y  (2)
    ) dut (
        .clk         (clk),
        .RST         (RST),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .credit_out  (credit_out),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_port    (out_port),
        .out_ready   (out_ready),
        .err_overflow(err_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [19:0] id;
        logic        rdy;
        logic        ev;
        logic [4:0]  ep;
        logic        chk_d;
        logic [19:0] ed;
        logic        ec;
        logic        eo;
    } vec_t;

    vec_t vecs[20];

    function automatic logic [19:0] mk(input int x, input int y, input int p);
        logic [2:0]  fx;
        logic [2:0]  fy;
        logic [13:0] fp;
        fx = 3'(x);
        fy = 3'(y);
        fp = 14'(p);
        return {fx, fy, fp};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic iv, input logic [19:0] id, input logic rdy);
        in_valid  = iv;
        in_data   = id;
        out_ready = rdy;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        drive(1'b0, 20'h0, 1'b0);
        repeat (2) @(negedge clk);
        RST = 1'b0;
    endtask

    logic [19:0] fa, fb, fc, fd, fe, fg, fh, fi, ff, z;
    int          run;

    initial begin
        checks = 0;
        errors = 0;
        drive(1'b0, 20'h0, 1'b0);
        do_reset();

        // Idle after reset
        repeat (5) @(negedge clk);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_port", 32'(out_port), 32'd0);
        check("rst_credit", 32'(credit_out), 32'd0);
        check("rst_ovf", 32'(err_overflow), 32'd0);

        fa = mk(3, 0, 1); fb = mk(1, 5, 2); fc = mk(2, 4, 3); fd = mk(2, 2, 4);
        fe = mk(2, 0, 5); fg = mk(2, 3, 6); fh = mk(3, 3, 7); fi = mk(0, 0, 8);
        ff = mk(1, 1, 9); z = 20'h0;

        // Expected values are the post-edge outputs for each applied input set.
        vecs[0]  = '{1'b1, fa, 1'b0, 1'b1, 5'b00010, 1'b1, fa, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, fb, 1'b0, 1'b1, 5'b00010, 1'b1, fa, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, fc, 1'b0, 1'b1, 5'b00010, 1'b1, fa, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, fd, 1'b0, 1'b1, 5'b00010, 1'b1, fa, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, z,  1'b1, 1'b1, 5'b00100, 1'b1, fb, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, z,  1'b1, 1'b1, 5'b01000, 1'b1, fc, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, z,  1'b1, 1'b1, 5'b00001, 1'b1, fd, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, z,  1'b1, 1'b0, 5'b00000, 1'b0, z,  1'b1, 1'b0};
        vecs[8]  = '{1'b0, z,  1'b0, 1'b0, 5'b00000, 1'b0, z,  1'b0, 1'b0};
        vecs[9]  = '{1'b0, z,  1'b1, 1'b0, 5'b00000, 1'b0, z,  1'b0, 1'b0};
        vecs[10] = '{1'b1, fe, 1'b0, 1'b1, 5'b10000, 1'b1, fe, 1'b0, 1'b0};
        vecs[11] = '{1'b1, fg, 1'b0, 1'b1, 5'b10000, 1'b1, fe, 1'b0, 1'b0};
        vecs[12] = '{1'b1, fh, 1'b0, 1'b1, 5'b10000, 1'b1, fe, 1'b0, 1'b0};
        vecs[13] = '{1'b1, fi, 1'b0, 1'b1, 5'b10000, 1'b1, fe, 1'b0, 1'b0};
        vecs[14] = '{1'b1, ff, 1'b1, 1'b1, 5'b01000, 1'b1, fg, 1'b1, 1'b1};
        vecs[15] = '{1'b0, z,  1'b0, 1'b1, 5'b01000, 1'b1, fg, 1'b0, 1'b1};
        vecs[16] = '{1'b0, z,  1'b1, 1'b1, 5'b00010, 1'b1, fh, 1'b1, 1'b1};
        vecs[17] = '{1'b0, z,  1'b1, 1'b1, 5'b00100, 1'b1, fi, 1'b1, 1'b1};
        vecs[18] = '{1'b0, z,  1'b1, 1'b0, 5'b00000, 1'b0, z,  1'b1, 1'b1};
        vecs[19] = '{1'b0, z,  1'b0, 1'b0, 5'b00000, 1'b0, z,  1'b0, 1'b1};

        for (int i = 0; i < 20; i++) begin
            drive(vecs[i].iv, vecs[i].id, vecs[i].rdy);
            @(negedge clk);
            check($sformatf("v%0d_valid", i), 32'(out_valid), 32'(vecs[i].ev));
            check($sformatf("v%0d_port", i), 32'(out_port), 32'(vecs[i].ep));
            if (vecs[i].chk_d) begin
                check($sformatf("v%0d_data", i), 32'(out_data), 32'(vecs[i].ed));
            end
            check($sformatf("v%0d_credit", i), 32'(credit_out), 32'(vecs[i].ec));
            check($sformatf("v%0d_ovf", i), 32'(err_overflow), 32'(vecs[i].eo));
        end

        // Streaming at one flit per cycle
        do_reset();
        run = 0;
        for (int k = 0; k <= 20; k++) begin
            if (k < 20) drive(1'b1, mk(2, 2, k), 1'b1);
            else        drive(1'b0, 20'h0, 1'b1);
            @(negedge clk);
            if (credit_out) run++;
            if (k < 20) begin
                check($sformatf("str%0d_valid", k), 32'(out_valid), 32'd1);
                check($sformatf("str%0d_payload", k), 32'(out_data[13:0]), 32'(k));
            end else begin
                check("str_end_valid", 32'(out_valid), 32'd0);
            end
        end
        drive(1'b0, 20'h0, 1'b0);
        @(negedge clk);
        check("str_credit_run", 32'(run), 32'd20);
        check("str_credit_low", 32'(credit_out), 32'd0);

        // Pointer wrap: three rounds of push 3 / pop 3
        for (int r = 0; r < 3; r++) begin
            for (int j = 0; j < 3; j++) begin
                drive(1'b1, mk(2, 2, 100 + r * 3 + j), 1'b0);
                @(negedge clk);
            end
            for (int j = 0; j < 3; j++) begin
                check($sformatf("wrap%0d_%0d", r, j), 32'(out_data[13:0]), 32'(100 + r * 3 + j));
                drive(1'b0, 20'h0, 1'b1);
                @(negedge clk);
            end
            check($sformatf("wrap%0d_empty", r), 32'(out_valid), 32'd0);
        end
        drive(1'b0, 20'h0, 1'b0);
        check("wrap_ovf", 32'(err_overflow), 32'd0);

        // Asynchronous reset with two flits buffered and a credit pending
        for (int j = 0; j < 3; j++) begin
            drive(1'b1, mk(3, 2, 200 + j), 1'b0);
            @(negedge clk);
        end
        drive(1'b0, 20'h0, 1'b1);
        @(negedge clk);
        drive(1'b0, 20'h0, 1'b0);
        check("pre_rst_credit", 32'(credit_out), 32'd1);
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        #2;
        RST = 1'b1;
        #1;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_credit", 32'(credit_out), 32'd0);
        check("async_rst_port", 32'(out_port), 32'd0);
        @(negedge clk);
        RST = 1'b0;
        @(negedge clk);
        check("post_rst_empty", 32'(out_valid), 32'd0);
        check("post_rst_credit", 32'(credit_out), 32'd0);
        drive(1'b1, mk(1, 2, 300), 1'b0);
        @(negedge clk);
        drive(1'b0, 20'h0, 1'b0);
        check("post_rst_head", 32'(out_data), 32'(mk(1, 2, 300)));
        check("post_rst_port", 32'(out_port), 32'b00100);
        check("post_rst_credit2", 32'(credit_out), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
